// File: rtl/flash_ctrl_pkg.sv
// Shared types for the flash fetch controller.
// FSM states, request size codes, flash byte-size constant.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_1B  = 2'd0,
    SZ_2B  = 2'd1,
    SZ_4B  = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  localparam logic [2:0] FLASH_BYTE_SIZE = 3'd1;

  function automatic logic [1:0] last_byte(size_e s);
    logic [1:0] r;
    case (s)
      SZ_1B:   r = 2'd0;
      SZ_2B:   r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, one-hot grant.
// Ports: clk, rst, req_i[1:0], accept_i, gnt_o[1:0].
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // id of the last granted requester
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= gnt_o[1];
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = last_q ? 2'b01 : 2'b10;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/flash_fetch_ctrl.sv
// Byte-serial flash read controller shared by two requesters.
// Ports: clk/rst, req0_*/req1_* request+response, flash_* byte port.
module flash_fetch_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [1:0]            req0_size,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [31:0]           req0_rdata,
  output logic                  req0_rerr,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [1:0]            req1_size,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [31:0]           req1_rdata,
  output logic                  req1_rerr,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  output logic                  flash_read_en,
  output logic [2:0]            flash_byte_size,
  input  logic [7:0]            flash_data,
  input  logic                  flash_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  size_e                 size_q, size_d;
  logic                  id_q, id_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  size_e      sel_size;

  assign req    = {req1_valid, req0_valid};
  assign accept = (state_q == IDLE) && (|req);
  assign sel_size = size_e'(gnt[1] ? req1_size : req0_size);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .accept_i(accept),
    .gnt_o   (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_1B;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d   = gnt[1];
          addr_d = gnt[1] ? req1_addr : req0_addr;
          size_d = sel_size;
          cnt_d  = '0;
          tmo_d  = '0;
          data_d = '0;
          err_d  = (sel_size == SZ_RSV);
          // reserved size takes one dead cycle in GAP so its
          // answer lands at the same latency as a 1-byte read
          state_d = (sel_size == SZ_RSV) ? GAP : RD;
        end
      end
      RD: begin
        if (flash_ready) begin
          tmo_d = '0;
          case (cnt_q)
            2'd0:    data_d[7:0]   = flash_data;
            2'd1:    data_d[15:8]  = flash_data;
            2'd2:    data_d[23:16] = flash_data;
            default: data_d[31:24] = flash_data;
          endcase
          state_d = (cnt_q == last_byte(size_q)) ? DONE : GAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = '0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (err_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q + 2'd1;
          state_d = RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];

  assign req0_rvalid = (state_q == DONE) & ~id_q;
  assign req1_rvalid = (state_q == DONE) & id_q;
  assign req0_rdata  = req0_rvalid ? data_q : '0;
  assign req1_rdata  = req1_rvalid ? data_q : '0;
  assign req0_rerr   = req0_rvalid & err_q;
  assign req1_rerr   = req1_rvalid & err_q;

  assign flash_read_en   = (state_q == RD);
  assign flash_addr      = addr_q;
  assign flash_byte_size = FLASH_BYTE_SIZE;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Self-checking bench for flash_fetch_ctrl.
// Scoreboard of expected responses, flash byte model.
module tb_flash_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        r_valid [2];
  logic [31:0] r_addr  [2];
  logic [1:0]  r_size  [2];
  logic        req0_ready, req1_ready;
  logic        req0_rvalid, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        req0_rerr, req1_rerr;
  logic [31:0] flash_addr;
  logic        flash_read_en;
  logic [2:0]  flash_byte_size;
  logic [7:0]  flash_data;
  logic        flash_ready;

  flash_fetch_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (r_valid[0]),
    .req0_addr      (r_addr[0]),
    .req0_size      (r_size[0]),
    .req0_ready     (req0_ready),
    .req0_rvalid    (req0_rvalid),
    .req0_rdata     (req0_rdata),
    .req0_rerr      (req0_rerr),
    .req1_valid     (r_valid[1]),
    .req1_addr      (r_addr[1]),
    .req1_size      (r_size[1]),
    .req1_ready     (req1_ready),
    .req1_rvalid    (req1_rvalid),
    .req1_rdata     (req1_rdata),
    .req1_rerr      (req1_rerr),
    .flash_addr     (flash_addr),
    .flash_read_en  (flash_read_en),
    .flash_byte_size(flash_byte_size),
    .flash_data     (flash_data),
    .flash_ready    (flash_ready)
  );

  typedef struct {
    int          id;
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [7:0] fmem [256];
  int   fl_wait = 0;
  bit   fl_dead = 0;
  int   en_cycles = 0;
  int   gaps[$];
  logic [31:0] addrs[$];
  bit   unstable = 0;
  bit   seen_hi = 0;
  int   low_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // flash byte model: ready after fl_wait cycles of read_en
  initial begin
    int   wcnt;
    bit   prev_en;
    logic [31:0] prev_addr;
    wcnt = 0;
    prev_en = 0;
    prev_addr = '0;
    flash_ready = 1'b0;
    flash_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (flash_read_en === 1'b1) begin
        en_cycles++;
        if (prev_en && flash_addr !== prev_addr) unstable = 1;
        if (seen_hi && low_run > 0) gaps.push_back(low_run);
        low_run = 0;
        seen_hi = 1;
        if (!fl_dead && wcnt >= fl_wait) begin
          flash_ready = 1'b1;
          flash_data = fmem[flash_addr[7:0]];
          addrs.push_back(flash_addr);
          wcnt = 0;
        end else begin
          flash_ready = 1'b0;
          wcnt++;
        end
      end else begin
        flash_ready = 1'b0;
        wcnt = 0;
        if (seen_hi) low_run++;
      end
      prev_en = (flash_read_en === 1'b1);
      prev_addr = flash_addr;
    end
  end

  // response monitor: pop the scoreboard on every rvalid
  initial begin
    exp_t        e;
    logic        rv, re;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (req0_rvalid === 1'b1 && req1_rvalid === 1'b1) begin
        n_bad++;
        $display("FAIL both_rvalid got 11 required at most one");
      end
      for (int p = 0; p < 2; p++) begin
        rv = p ? req1_rvalid : req0_rvalid;
        rd = p ? req1_rdata : req0_rdata;
        re = p ? req1_rerr : req0_rerr;
        n_cmp++;
        if (rv === 1'b1) begin
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rvalid port%0d got 1 required 0 cyc=%0d", p, cyc);
          end else begin
            e = sb.pop_front();
            if (e.id !== p || e.data !== rd || e.err !== re || e.due !== cyc) begin
              n_bad++;
              $display("FAIL response got port%0d data=%h err=%b cyc=%0d required port%0d data=%h err=%b cyc=%0d",
                       p, rd, re, cyc, e.id, e.data, e.err, e.due);
            end
          end
        end else if (rd !== 32'h0 || re !== 1'b0 || rv !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_port%0d got rvalid=%b rdata=%h rerr=%b required 0/0/0", p, rv, rd, re);
        end
      end
    end
  end

  task automatic drive(input int id, input logic [31:0] a, input logic [1:0] sz,
                       input int lat, input logic [31:0] d, input logic err,
                       output int acc);
    logic rdy;
    @(negedge clk);
    r_addr[id] = a;
    r_size[id] = sz;
    r_valid[id] = 1'b1;
    acc = -1;
    for (int k = 0; k < 400; k++) begin
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy === 1'b1) begin
        acc = cyc;
        sb.push_back('{id, cyc + lat, d, err});
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (acc < 0) begin
      n_bad++;
      $display("FAIL accept_timeout req%0d got no ready required ready", id);
    end
    @(posedge clk);
    #1;
    r_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_hist();
    en_cycles = 0;
    gaps.delete();
    addrs.delete();
    unstable = 0;
    seen_hi = 0;
    low_run = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (flash_read_en !== 1'b0 || flash_addr !== 32'h0 || flash_byte_size !== 3'd1 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got en=%b addr=%h bsz=%0d rdy=%b%b required 0/0/1/00",
               flash_read_en, flash_addr, flash_byte_size, req1_ready, req0_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_4b();
    int a;
    clear_hist();
    drive(0, 32'h10, 2'd2, 8, 32'h4433_2211, 1'b0, a);
    drain();
    n_cmp++;
    if (addrs.size() != 4 || addrs[0] !== 32'h10 || addrs[3] !== 32'h13) begin
      n_bad++;
      $display("FAIL addr_4b got n=%0d required 4 beats 0x10..0x13", addrs.size());
    end
  endtask

  task automatic test_tie();
    int a0, a1;
    fork
      drive(0, 32'h10, 2'd0, 2, 32'h0000_0011, 1'b0, a0);
      drive(1, 32'h11, 2'd0, 2, 32'h0000_0022, 1'b0, a1);
    join
    n_cmp++;
    if (a1 != a0 + 3) begin
      n_bad++;
      $display("FAIL tie1_order got acc0=%0d acc1=%0d required acc1=acc0+3", a0, a1);
    end
    drain();
    fork
      drive(0, 32'h12, 2'd0, 2, 32'h0000_0033, 1'b0, a0);
      drive(1, 32'h13, 2'd0, 2, 32'h0000_0044, 1'b0, a1);
    join
    n_cmp++;
    if (a1 != a0 + 3) begin
      n_bad++;
      $display("FAIL tie2_order got acc0=%0d acc1=%0d required acc1=acc0+3", a0, a1);
    end
    drain();
  endtask

  task automatic test_gap();
    int a;
    clear_hist();
    fl_wait = 3;
    drive(1, 32'h7, 2'd1, 10, 32'h0000_BBAA, 1'b0, a);
    drain();
    fl_wait = 0;
    n_cmp++;
    if (gaps.size() != 1 || gaps[0] != 1) begin
      n_bad++;
      $display("FAIL gap_len got n=%0d first=%0d required one gap of 1",
               gaps.size(), gaps.size() ? gaps[0] : -1);
    end
    n_cmp++;
    if (addrs.size() != 2 || addrs[0] !== 32'h7 || addrs[1] !== 32'h8 || unstable) begin
      n_bad++;
      $display("FAIL gap_addrs got n=%0d unstable=%0d required 0x7,0x8 stable", addrs.size(), unstable);
    end
  endtask

  task automatic test_timeout();
    int a;
    clear_hist();
    fl_dead = 1;
    drive(0, 32'h40, 2'd2, 65, 32'h0, 1'b1, a);
    drain();
    fl_dead = 0;
    n_cmp++;
    if (en_cycles != 64) begin
      n_bad++;
      $display("FAIL timeout_rd_cycles got %0d required 64", en_cycles);
    end
  endtask

  task automatic test_rsv();
    int a;
    clear_hist();
    drive(1, 32'h20, 2'd3, 2, 32'h0, 1'b1, a);
    drain();
    n_cmp++;
    if (en_cycles != 0) begin
      n_bad++;
      $display("FAIL rsv_no_read got %0d read cycles required 0", en_cycles);
    end
  endtask

  task automatic test_wrap();
    int a;
    clear_hist();
    drive(0, 32'hFFFF_FFFF, 2'd1, 4, 32'h0000_5AA5, 1'b0, a);
    drain();
    n_cmp++;
    if (addrs.size() != 2 || addrs[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_addr got n=%0d required second beat at 0", addrs.size());
    end
  endtask

  task automatic test_rst_abort();
    int  a;
    bit  hit;
    drive(0, 32'h20, 2'd2, 8, 32'h0, 1'b0, a);
    hit = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (flash_read_en === 1'b1 && flash_addr === 32'h22) begin
        hit = 1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL abort_third_byte got no RD at 0x22 required one");
    end
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (flash_read_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_read_en got %b required 0", flash_read_en);
    end
    repeat (12) @(negedge clk);
    drive(0, 32'h10, 2'd2, 8, 32'h4433_2211, 1'b0, a);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fmem[i] = 8'(i) ^ 8'h5A;
    fmem[8'h10] = 8'h11;
    fmem[8'h11] = 8'h22;
    fmem[8'h12] = 8'h33;
    fmem[8'h13] = 8'h44;
    fmem[8'h07] = 8'hAA;
    fmem[8'h08] = 8'hBB;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 1'b0;
      r_addr[i] = '0;
      r_size[i] = '0;
    end
    test_reset();
    test_tie();
    test_4b();
    test_gap();
    test_timeout();
    test_rsv();
    test_wrap();
    test_rst_abort();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang required finish");
    $fatal(1, "timeout");
  end

endmodule
